// File: rtl/pce_stream_if.sv
// Bit-serial handshake bundle between the payload FIFO side and the encoder,
// plus the encoded-bit stream toward the interleaver/mapper.
interface pce_stream_if #(
  parameter int KLEN_W = 13
);
  logic [KLEN_W-1:0] k_len;
  logic              in_valid;
  logic              din;
  logic              in_ready;
  logic              out_valid;
  logic              out_data;
  logic              out_first;
  logic              out_last;
  logic              out_ready;
  logic              encode_busy;

  modport master (
    output k_len, in_valid, din, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_last, encode_busy
  );

  modport slave (
    input  k_len, in_valid, din, out_ready,
    output in_ready, out_valid, out_data, out_first, out_last, encode_busy
  );
endinterface

// File: rtl/pce_stream.sv
// Streaming systematic encoder: forwards K info bits, then appends PAR_W
// generator-polynomial parity bits MSB first, with backpressure on both sides.
module pce_stream #(
  parameter int              PAR_W    = 16,
  parameter logic [PAR_W-1:0] GEN_POLY = 16'h1021,
  parameter int              KLEN_W   = 13
) (
  input  logic        clk,
  input  logic        rst,
  pce_stream_if.slave bus
);
  localparam int PCNT_W = $clog2(PAR_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INFO   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [PAR_W-1:0]   lfsr_r;
  logic [KLEN_W-1:0]  cnt_r, klen_r, klen_s, cnt_inc_s;
  logic [PCNT_W-1:0]  pcnt_r;
  logic               out_valid_r, out_data_r, out_first_r, out_last_r;
  logic               slot_s, in_ready_s, accept_s, emit_par_s;

  function automatic logic [PAR_W-1:0] lfsr_step(input logic [PAR_W-1:0] r, input logic b);
    logic fb;
    fb = b ^ r[PAR_W-1];
    return {r[PAR_W-2:0], 1'b0} ^ (fb ? GEN_POLY : {PAR_W{1'b0}});
  endfunction

  // Handshake qualifiers and next-state decode
  always_comb begin
    slot_s     = !out_valid_r || bus.out_ready;
    in_ready_s = !rst && (state_r != PARITY) && slot_s;
    accept_s   = bus.in_valid && in_ready_s;
    emit_par_s = (state_r == PARITY) && slot_s;
    klen_s     = (bus.k_len == {KLEN_W{1'b0}}) ? KLEN_W'(1) : bus.k_len;
    cnt_inc_s  = cnt_r + KLEN_W'(1);
    state_s    = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (klen_s == KLEN_W'(1)) state_s = PARITY;
          else                      state_s = INFO;
        end else begin
          state_s = IDLE;
        end
      end
      INFO: begin
        if (accept_s && (cnt_inc_s == klen_r)) state_s = PARITY;
        else                                   state_s = INFO;
      end
      PARITY: begin
        if (emit_par_s && (pcnt_r == {PCNT_W{1'b0}})) state_s = IDLE;
        else                                           state_s = PARITY;
      end
      default: state_s = IDLE;
    endcase
  end

  // Frame state, bit counters and parity register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      lfsr_r  <= {PAR_W{1'b0}};
      cnt_r   <= {KLEN_W{1'b0}};
      klen_r  <= {KLEN_W{1'b0}};
      pcnt_r  <= {PCNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        // A frame start clears the remainder before folding in the first bit.
        lfsr_r <= lfsr_step((state_r == IDLE) ? {PAR_W{1'b0}} : lfsr_r, bus.din);
        cnt_r  <= (state_r == IDLE) ? KLEN_W'(1) : cnt_inc_s;
        pcnt_r <= PCNT_W'(PAR_W - 1);
        if (state_r == IDLE) klen_r <= klen_s;
      end else if (emit_par_s) begin
        lfsr_r <= {lfsr_r[PAR_W-2:0], 1'b0};
        pcnt_r <= pcnt_r - PCNT_W'(1);
      end
    end
  end

  // Output register: refills only when empty or being consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 1'b0;
      out_first_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (slot_s) begin
      if (accept_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= bus.din;
        out_first_r <= (state_r == IDLE);
        out_last_r  <= 1'b0;
      end else if (emit_par_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= lfsr_r[PAR_W-1];
        out_first_r <= 1'b0;
        out_last_r  <= (pcnt_r == {PCNT_W{1'b0}});
      end else begin
        out_valid_r <= 1'b0;
        out_data_r  <= 1'b0;
        out_first_r <= 1'b0;
        out_last_r  <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_data    = out_data_r;
  assign bus.out_first   = out_first_r;
  assign bus.out_last    = out_last_r;
  assign bus.encode_busy = (state_r != IDLE) || out_valid_r;
endmodule

// File: tb/tb_pce_stream.sv
// Scoreboard bench: an 8-bit parity instance for directed/random frames and
// a default 16-bit instance for the ASCII "123456789" check value.
module tb_pce_stream;
  localparam int         P  = 8;
  localparam logic [7:0] G  = 8'h07;
  localparam int         KW = 13;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pce_stream_if #(.KLEN_W(KW)) a_if ();
  pce_stream_if #(.KLEN_W(KW)) b_if ();

  pce_stream #(.PAR_W(P), .GEN_POLY(G), .KLEN_W(KW)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  pce_stream #(.PAR_W(16), .GEN_POLY(16'h1021), .KLEN_W(KW)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  typedef struct packed {logic d; logic f; logic l;} exp_t;
  exp_t qa[$];
  exp_t qb[$];
  logic msg [0:8191];

  int checks = 0, errors = 0, timeouts = 0, seen_to = 0;
  bit mon_en = 1'b1, b2b_chk = 1'b0, chk_noready = 1'b0, chk_zero = 1'b0, chk_end = 1'b0, rnd_rdy = 1'b0;
  int exp_busy = -1;

  // Reference parity by polynomial long division of msg(x)*x^P by G(x)
  function automatic logic [7:0] model_par(input int k);
    logic       w [0:8199];
    logic [8:0] g;
    logic [7:0] par;
    g = {1'b1, G};
    for (int i = 0; i < k + P; i++) w[i] = (i < k) ? msg[i] : 1'b0;
    for (int i = 0; i < k; i++)
      if (w[i]) for (int j = 0; j <= P; j++) w[i+j] = w[i+j] ^ g[P-j];
    for (int j = 0; j < P; j++) par[P-1-j] = w[k+j];
    return par;
  endfunction

  initial begin : ready_gen
    a_if.out_ready = 1'b1;
    b_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 a_if.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    exp_t e;
    int   cyc, last_cyc;
    bit   stall_prev;
    logic [2:0] held;
    cyc = 0; last_cyc = -10; stall_prev = 1'b0; held = 3'b000;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (a_if.out_valid && a_if.out_ready) begin
          checks++;
          if (qa.size() == 0) begin
            errors++;
            $display("FAIL a_unexpected: got bit=%0b first=%0b last=%0b, required no output", a_if.out_data, a_if.out_first, a_if.out_last);
          end else begin
            e = qa.pop_front();
            if ({a_if.out_data, a_if.out_first, a_if.out_last} !== {e.d, e.f, e.l}) begin
              errors++;
              $display("FAIL a_stream: got d/f/l=%b, required %b", {a_if.out_data, a_if.out_first, a_if.out_last}, {e.d, e.f, e.l});
            end
          end
          if (b2b_chk && a_if.out_first) begin
            checks++;
            if (last_cyc != cyc - 1) begin
              errors++;
              $display("FAIL b2b_gap: out_first at cycle %0d, last out_last at %0d, required %0d", cyc, last_cyc, cyc - 1);
            end
          end
          if (a_if.out_last) last_cyc = cyc;
        end
        if (stall_prev) begin
          checks++;
          if (!a_if.out_valid || {a_if.out_data, a_if.out_first, a_if.out_last} !== held) begin
            errors++;
            $display("FAIL stall_hold: got v=%0b d/f/l=%b, required v=1 d/f/l=%b", a_if.out_valid, {a_if.out_data, a_if.out_first, a_if.out_last}, held);
          end
        end
        stall_prev = a_if.out_valid && !a_if.out_ready;
        held = {a_if.out_data, a_if.out_first, a_if.out_last};
      end else begin
        stall_prev = 1'b0;
      end
      if (b_if.out_valid && b_if.out_ready) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected: got bit=%0b, required no output", b_if.out_data);
        end else begin
          e = qb.pop_front();
          if ({b_if.out_data, b_if.out_first, b_if.out_last} !== {e.d, e.f, e.l}) begin
            errors++;
            $display("FAIL b_stream: got d/f/l=%b, required %b", {b_if.out_data, b_if.out_first, b_if.out_last}, {e.d, e.f, e.l});
          end
        end
      end
      if (chk_noready) begin
        checks++;
        if (a_if.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL parity_in_ready: got %0b, required 0", a_if.in_ready);
        end
      end
      if (chk_zero) begin
        checks++;
        if ({a_if.in_ready, a_if.out_valid, a_if.out_data, a_if.out_first, a_if.out_last, a_if.encode_busy,
             b_if.in_ready, b_if.out_valid, b_if.out_data, b_if.out_first, b_if.out_last, b_if.encode_busy} !== 12'h000) begin
          errors++;
          $display("FAIL reset_outputs: got a=%b b=%b, required all 0",
                   {a_if.in_ready, a_if.out_valid, a_if.out_data, a_if.out_first, a_if.out_last, a_if.encode_busy},
                   {b_if.in_ready, b_if.out_valid, b_if.out_data, b_if.out_first, b_if.out_last, b_if.encode_busy});
        end
      end
      if (exp_busy >= 0) begin
        checks++;
        if (a_if.encode_busy !== exp_busy[0]) begin
          errors++;
          $display("FAIL encode_busy: got %0b, required %0d", a_if.encode_busy, exp_busy);
        end
      end
      if (chk_end) begin
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
          errors++;
          $display("FAIL leftover: got %0d/%0d pending bits, required 0/0", qa.size(), qb.size());
        end
      end
      if (timeouts != seen_to) begin
        checks++;
        errors++;
        $display("FAIL timeout: got %0d expired waits, required 0", timeouts);
        seen_to = timeouts;
      end
    end
  end

  task automatic send_frame(input int kf, input bit use_model, input logic [7:0] hp, input bit rnd_v);
    int k, i, guard, pend;
    logic [7:0] par;
    bit acc;
    if (timeouts > 0) return;
    k = (kf == 0) ? 1 : kf;
    par = use_model ? model_par(k) : hp;
    for (int ii = 0; ii < k; ii++) qa.push_back(exp_t'{d: msg[ii], f: (ii == 0), l: 1'b0});
    for (int j = 0; j < P; j++) qa.push_back(exp_t'{d: par[P-1-j], f: 1'b0, l: (j == P - 1)});
    a_if.k_len = KW'(kf);
    i = 0; guard = 0;
    while (i < k && guard < 40 * k + 100) begin
      a_if.din = msg[i];
      a_if.in_valid = rnd_v ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      acc = a_if.in_valid && a_if.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        i++;
        if (i == 1) a_if.k_len = KW'($urandom_range(0, 8191));
      end
      guard++;
    end
    a_if.in_valid = 1'b0;
    if (i < k) timeouts++;
    pend = P; guard = 0;
    chk_noready = (i == k);
    while (pend > 0 && guard < 1000) begin
      @(negedge clk);
      if (!a_if.out_valid || a_if.out_ready) pend--;
      @(posedge clk); #1;
      guard++;
    end
    chk_noready = 1'b0;
    if (pend > 0) timeouts++;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((qa.size() != 0 || qb.size() != 0 || a_if.encode_busy || b_if.encode_busy) && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20000) timeouts++;
  endtask

  task automatic reset_test(input int kf, input int ncyc);
    mon_en = 1'b0;
    a_if.k_len = KW'(kf); a_if.din = 1'b1; a_if.in_valid = 1'b1;
    repeat (ncyc) @(posedge clk);
    #1;
    a_if.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_zero = 1'b1;
    @(posedge clk); #1;
    chk_zero = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;
    msg[0] = 1'b1; msg[1] = 1'b0;
    send_frame(2, 1'b0, 8'h0E, 1'b0);
    drain();
  endtask

  task automatic send_b();
    logic [71:0]  s;
    logic [15:0]  crc;
    int i, guard;
    bit acc;
    s = "123456789";
    crc = 16'h31C3;
    for (int ii = 0; ii < 72; ii++) qb.push_back(exp_t'{d: s[71-ii], f: (ii == 0), l: 1'b0});
    for (int j = 0; j < 16; j++) qb.push_back(exp_t'{d: crc[15-j], f: 1'b0, l: (j == 15)});
    b_if.k_len = KW'(72);
    i = 0; guard = 0;
    while (i < 72 && guard < 500) begin
      b_if.din = s[71-i];
      b_if.in_valid = 1'b1;
      @(negedge clk);
      acc = b_if.in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    b_if.in_valid = 1'b0;
    if (i < 72) timeouts++;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int k;
    rst = 1'b1;
    a_if.k_len = '0; a_if.in_valid = 1'b0; a_if.din = 1'b0;
    b_if.k_len = '0; b_if.in_valid = 1'b0; b_if.din = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_zero = 1'b1;
    @(posedge clk); #1;
    chk_zero = 1'b0;
    rst = 1'b0;

    msg[0] = 1'b1;
    send_frame(1, 1'b0, 8'h07, 1'b0);
    msg[0] = 1'b1; msg[1] = 1'b0;
    send_frame(2, 1'b0, 8'h0E, 1'b0);
    for (int i = 0; i < 8; i++) msg[i] = 1'b0;
    send_frame(8, 1'b0, 8'h00, 1'b0);
    exp_busy = 1;
    @(posedge clk); #1;
    exp_busy = 0;
    @(posedge clk); #1;
    exp_busy = -1;

    // k_len=0 behaves as 1, then back-to-back frames with no gap
    msg[0] = 1'b1;
    send_frame(0, 1'b0, 8'h07, 1'b0);
    b2b_chk = 1'b1;
    msg[0] = 1'b1; msg[1] = 1'b0;
    send_frame(2, 1'b0, 8'h0E, 1'b0);
    msg[0] = 1'b1; msg[1] = 1'b0; msg[2] = 1'b1; msg[3] = 1'b1; msg[4] = 1'b0;
    send_frame(5, 1'b1, 8'h00, 1'b0);
    b2b_chk = 1'b0;

    rnd_rdy = 1'b1;
    for (int f = 0; f < 30; f++) begin
      k = $urandom_range(1, 200);
      for (int i = 0; i < k; i++) msg[i] = 1'($urandom_range(0, 1));
      send_frame(k, 1'b1, 8'h00, 1'b1);
    end
    for (int i = 0; i < 4319; i++) msg[i] = 1'($urandom_range(0, 1));
    send_frame(4319, 1'b1, 8'h00, 1'b1);
    rnd_rdy = 1'b0;
    for (int i = 0; i < 8191; i++) msg[i] = 1'($urandom_range(0, 1));
    send_frame(8191, 1'b1, 8'h00, 1'b0);
    drain();

    reset_test(10, 4);
    reset_test(3, 5);

    send_b();
    drain();

    chk_end = 1'b1;
    @(posedge clk); #1;
    chk_end = 1'b0;
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
